// File: rtl/mcp_rx_capture.sv
// Multi-cycle-path word receiver for the clk2 domain: synchronizes a toggle request,
// waits a settle margin, captures into a one-entry valid/ready buffer and returns a toggle ack.
// Optional even-parity check is enabled with the MCP_RX_PARITY_EN macro.
module mcp_rx_capture #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int SETTLE_CYC  = 1,
  parameter int CNT_W       = 16
) (
  input  logic             clk2,
  input  logic             reset,
  input  logic             req_toggle,
  input  logic [WIDTH-1:0] data_in,
`ifdef MCP_RX_PARITY_EN
  input  logic             data_par,
  output logic             par_err,
`endif
  output logic             ack_toggle,
  output logic [WIDTH-1:0] data_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic [CNT_W-1:0] xfer_cnt,
  output logic [1:0]       state_dbg
);

  // Handshake: the buffer word transfers on any clk2 edge where out_valid && out_ready;
  // out_valid stays high and data_out stays constant until that edge.

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SETTLE   = 2'd1,
    WAIT_BUF = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   req_seen;
  logic [3:0]             cnt_q, cnt_d;
  logic                   req_sync;
  logic                   new_req;
  logic                   buf_free;
  logic                   capture;

  assign req_sync  = sync_q[SYNC_STAGES-1];
  assign new_req   = req_sync ^ req_seen;
  assign buf_free  = !out_valid || out_ready;
  assign busy      = (state_q != IDLE);
  assign state_dbg = state_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (new_req) begin
          state_d = SETTLE;
          cnt_d   = 4'(SETTLE_CYC);
        end
      end
      SETTLE: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else if (buf_free) begin
          capture = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = WAIT_BUF;
        end
      end
      WAIT_BUF: begin
        // Ack is withheld here, so data_in is still guaranteed stable at capture.
        if (buf_free) begin
          capture = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk2) begin
    if (reset) begin
      sync_q     <= '0;
      req_seen   <= 1'b0;
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      ack_toggle <= 1'b0;
      data_out   <= '0;
      out_valid  <= 1'b0;
      xfer_cnt   <= '0;
`ifdef MCP_RX_PARITY_EN
      par_err    <= 1'b0;
`endif
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], req_toggle};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture) begin
        data_out   <= data_in;
        out_valid  <= 1'b1;
        ack_toggle <= ~ack_toggle;
        req_seen   <= req_sync;
        xfer_cnt   <= xfer_cnt + CNT_W'(1);
`ifdef MCP_RX_PARITY_EN
        par_err    <= ^{data_in, data_par};
`endif
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
`ifdef MCP_RX_PARITY_EN
        par_err   <= 1'b0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_mcp_rx_capture.sv
// Directed bench for mcp_rx_capture: three parameterizations share one source, checked
// against a hand-computed vector table plus backpressure and mid-transfer reset sequences.
module tb_mcp_rx_capture;

  localparam int LAT_A = 5;  // SYNC 2 + SETTLE 1 + 2
  localparam int LAT_B = 5;  // SYNC 3 + SETTLE 0 + 2
  localparam int LAT_C = 8;  // SYNC 3 + SETTLE 3 + 2

  logic       clk2 = 1'b0;
  logic       reset;
  logic       req_toggle;
  logic [7:0] data_in;
  logic       ready_a;
  logic       ready_bc;
`ifdef MCP_RX_PARITY_EN
  logic       data_par;
  logic       par_err_a, par_err_b, par_err_c;
`endif

  logic        ack_a, ack_b, ack_c;
  logic [7:0]  dout_a, dout_b, dout_c;
  logic        vld_a, vld_b, vld_c;
  logic        busy_a, busy_b, busy_c;
  logic [15:0] cnt_a, cnt_c;
  logic [1:0]  cnt_b;
  logic [1:0]  st_a, st_b, st_c;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk2 = ~clk2;

  mcp_rx_capture #(.WIDTH(8), .SYNC_STAGES(2), .SETTLE_CYC(1), .CNT_W(16)) dut_a (
    .clk2(clk2), .reset(reset), .req_toggle(req_toggle), .data_in(data_in),
`ifdef MCP_RX_PARITY_EN
    .data_par(data_par), .par_err(par_err_a),
`endif
    .ack_toggle(ack_a), .data_out(dout_a), .out_valid(vld_a), .out_ready(ready_a),
    .busy(busy_a), .xfer_cnt(cnt_a), .state_dbg(st_a)
  );

  mcp_rx_capture #(.WIDTH(8), .SYNC_STAGES(3), .SETTLE_CYC(0), .CNT_W(2)) dut_b (
    .clk2(clk2), .reset(reset), .req_toggle(req_toggle), .data_in(data_in),
`ifdef MCP_RX_PARITY_EN
    .data_par(data_par), .par_err(par_err_b),
`endif
    .ack_toggle(ack_b), .data_out(dout_b), .out_valid(vld_b), .out_ready(ready_bc),
    .busy(busy_b), .xfer_cnt(cnt_b), .state_dbg(st_b)
  );

  mcp_rx_capture #(.WIDTH(8), .SYNC_STAGES(3), .SETTLE_CYC(3), .CNT_W(16)) dut_c (
    .clk2(clk2), .reset(reset), .req_toggle(req_toggle), .data_in(data_in),
`ifdef MCP_RX_PARITY_EN
    .data_par(data_par), .par_err(par_err_c),
`endif
    .ack_toggle(ack_c), .data_out(dout_c), .out_valid(vld_c), .out_ready(ready_bc),
    .busy(busy_c), .xfer_cnt(cnt_c), .state_dbg(st_c)
  );

  typedef struct {
    logic [7:0]  d;
    logic        p;
    logic [15:0] exp_cnt;
    logic [1:0]  exp_cnt_b;
    logic        exp_ack;
    logic        exp_perr;
  } vec_t;

  vec_t vecs[5];

  int         lat_a, lat_b, lat_c;
  logic [7:0] cap_a, cap_b, cap_c;
  logic       vnext_a;
  logic       perr_a;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk2);
    #1;
  endtask

  // Toggle the request with a new word and record first-valid edge and captured data per DUT.
  task automatic xfer(input logic [7:0] d, input logic p);
    data_in = d;
`ifdef MCP_RX_PARITY_EN
    data_par = p;
`else
    if (p) data_in = d;
`endif
    req_toggle = ~req_toggle;
    lat_a = 0; lat_b = 0; lat_c = 0;
    vnext_a = 1'b1;
    perr_a = 1'b0;
    for (int n = 1; n <= 14; n++) begin
      step();
      if (lat_a != 0 && n == lat_a + 1) vnext_a = vld_a;
      if (lat_a == 0 && vld_a) begin
        lat_a = n; cap_a = dout_a;
`ifdef MCP_RX_PARITY_EN
        perr_a = par_err_a;
`endif
      end
      if (lat_b == 0 && vld_b) begin lat_b = n; cap_b = dout_b; end
      if (lat_c == 0 && vld_c) begin lat_c = n; cap_c = dout_c; end
    end
  endtask

  initial begin
    vecs[0] = '{8'hA5, 1'b0, 16'd1, 2'd1, 1'b1, 1'b0};
    vecs[1] = '{8'h01, 1'b0, 16'd2, 2'd2, 1'b0, 1'b1};
    vecs[2] = '{8'h01, 1'b1, 16'd3, 2'd3, 1'b1, 1'b0};
    vecs[3] = '{8'h3C, 1'b0, 16'd4, 2'd0, 1'b0, 1'b0};
    vecs[4] = '{8'h7F, 1'b1, 16'd5, 2'd1, 1'b1, 1'b0};

    reset = 1'b1; req_toggle = 1'b0; data_in = 8'h00; ready_a = 1'b1; ready_bc = 1'b1;
`ifdef MCP_RX_PARITY_EN
    data_par = 1'b0;
`endif
    repeat (3) step();
    reset = 1'b0;
    step();
    check("rst_valid", 32'(vld_a), 32'd0);
    check("rst_dout", 32'(dout_a), 32'd0);
    check("rst_ack", 32'(ack_a), 32'd0);
    check("rst_cnt", 32'(cnt_a), 32'd0);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_state", 32'(st_a), 32'd0);

    for (int i = 0; i < 5; i++) begin
      xfer(vecs[i].d, vecs[i].p);
      check($sformatf("v%0d_lat_a", i), 32'(lat_a), 32'(LAT_A));
      check($sformatf("v%0d_lat_b", i), 32'(lat_b), 32'(LAT_B));
      check($sformatf("v%0d_lat_c", i), 32'(lat_c), 32'(LAT_C));
      check($sformatf("v%0d_data_a", i), 32'(cap_a), 32'(vecs[i].d));
      check($sformatf("v%0d_data_b", i), 32'(cap_b), 32'(vecs[i].d));
      check($sformatf("v%0d_data_c", i), 32'(cap_c), 32'(vecs[i].d));
      check($sformatf("v%0d_drop_a", i), 32'(vnext_a), 32'd0);
      check($sformatf("v%0d_ack", i), 32'({ack_a, ack_b, ack_c}), 32'({3{vecs[i].exp_ack}}));
      check($sformatf("v%0d_cnt_a", i), 32'(cnt_a), 32'(vecs[i].exp_cnt));
      check($sformatf("v%0d_cnt_b", i), 32'(cnt_b), 32'(vecs[i].exp_cnt_b));
      check($sformatf("v%0d_cnt_c", i), 32'(cnt_c), 32'(vecs[i].exp_cnt));
      check($sformatf("v%0d_idle", i), 32'({busy_a, busy_b, busy_c, st_a, st_b, st_c, vld_a, vld_b, vld_c}), 32'd0);
`ifdef MCP_RX_PARITY_EN
      check($sformatf("v%0d_perr_a", i), 32'(perr_a), 32'(vecs[i].exp_perr));
      check($sformatf("v%0d_perr_clr", i), 32'({par_err_a, par_err_b, par_err_c}), 32'd0);
`endif
    end

    // Backpressure: first word parked, second request must wait without ack.
    ready_a = 1'b0;
    xfer(8'h3C, 1'b0);
    check("bp_first_valid", 32'(vld_a), 32'd1);
    check("bp_first_data", 32'(dout_a), 32'h3C);
    check("bp_first_ack", 32'(ack_a), 32'd0);
    check("bp_first_cnt", 32'(cnt_a), 32'd6);
    xfer(8'hC3, 1'b0);
    check("bp_hold_data", 32'(dout_a), 32'h3C);
    check("bp_hold_ack", 32'(ack_a), 32'd0);
    check("bp_hold_cnt", 32'(cnt_a), 32'd6);
    check("bp_hold_state", 32'(st_a), 32'd2);
    check("bp_hold_busy", 32'(busy_a), 32'd1);
    ready_a = 1'b1;
    step();
    check("bp_load_valid", 32'(vld_a), 32'd1);
    check("bp_load_data", 32'(dout_a), 32'hC3);
    check("bp_load_ack", 32'(ack_a), 32'd1);
    check("bp_load_cnt", 32'(cnt_a), 32'd7);
    check("bp_load_busy", 32'(busy_a), 32'd0);
    step();
    check("bp_drain_valid", 32'(vld_a), 32'd0);
    check("bp_drain_data", 32'(dout_a), 32'hC3);

    // Reset while dut_a sits in SETTLE aborts the transfer without capture or ack.
    data_in = 8'h55;
    req_toggle = ~req_toggle;
    repeat (3) step();
    check("mid_state_settle", 32'(st_a), 32'd1);
    reset = 1'b1;
    req_toggle = 1'b0;
    step();
    reset = 1'b0;
    check("mid_rst_valid", 32'(vld_a), 32'd0);
    check("mid_rst_ack", 32'(ack_a), 32'd0);
    check("mid_rst_cnt", 32'(cnt_a), 32'd0);
    check("mid_rst_state", 32'(st_a), 32'd0);
    repeat (10) step();
    check("mid_quiet", 32'({vld_a, ack_a, busy_a}), 32'd0);
    xfer(8'h96, 1'b0);
    check("post_lat_a", 32'(lat_a), 32'(LAT_A));
    check("post_data_a", 32'(cap_a), 32'h96);
    check("post_ack_a", 32'(ack_a), 32'd1);
    check("post_cnt_a", 32'(cnt_a), 32'd1);
    check("post_cnt_b", 32'(cnt_b), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
